// File: rtl/ofs_plat_prim_arb_wrr_pkt.sv
// Weighted round-robin arbiter with packet locking. Grant is combinational;
// a client that starts a multi-beat packet keeps the channel until its eop beat.
module ofs_plat_prim_arb_wrr_pkt #(
  parameter int NUM_CLIENTS  = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                ena,
  input  logic [NUM_CLIENTS-1:0]              request,
  input  logic [NUM_CLIENTS-1:0]              eop,
  input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] weight,
  output logic [NUM_CLIENTS-1:0]              grant,
  output logic [IDX_W-1:0]                    grantIdx,
  output logic                                valid,
  output logic                                locked
);

  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             xfer;

  assign xfer   = ena & valid;
  assign locked = locked_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  generate
    if (NUM_CLIENTS == 1) begin : g_single
      // Only one requester: no rotation, just track packet boundaries.
      logic unused_weight;
      assign unused_weight = ^weight;

      always_comb begin
        valid    = request[0];
        grantIdx = '0;
        grant    = ena & request[0];
      end

      always_comb begin
        locked_d   = locked_q;
        lock_idx_d = '0;
        if (xfer) begin
          locked_d = ~eop[0];
        end
      end
    end else begin : g_multi
      logic [NUM_CLIENTS-1:0]  base_q, base_d;
      logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
      logic [IDX_W-1:0]        credit_owner_q, credit_owner_d;

      logic [IDX_W-1:0]        base_idx;
      logic [IDX_W-1:0]        rr_idx;
      logic                    rr_found;
      logic [IDX_W-1:0]        cand;
      logic [WEIGHT_WIDTH-1:0] w_sel;
      logic [WEIGHT_WIDTH-1:0] w_eff;
      logic [WEIGHT_WIDTH-1:0] cnt;

      always_comb begin
        base_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (base_q[i]) begin
            base_idx = IDX_W'(i);
          end
        end
      end

      // Scan upward from base, wrapping, for the first requester.
      always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
          idx = int'(base_idx) + k;
          if (idx >= NUM_CLIENTS) begin
            idx = idx - NUM_CLIENTS;
          end
          if (!rr_found && request[idx]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(idx);
          end
        end
      end

      always_comb begin
        cand     = locked_q ? lock_idx_q : rr_idx;
        valid    = locked_q ? request[lock_idx_q] : rr_found;
        grantIdx = cand;
        grant    = '0;
        if (valid) begin
          grant = (NUM_CLIENTS'(1) << cand) & {NUM_CLIENTS{ena}};
        end
      end

      // Packet count toward the winner's quantum, saturating.
      always_comb begin
        w_sel = weight[int'(cand)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        w_eff = (w_sel == '0) ? WEIGHT_WIDTH'(1) : w_sel;
        if (credit_owner_q == cand) begin
          cnt = (credit_q == '1) ? credit_q : credit_q + 1'b1;
        end else begin
          cnt = WEIGHT_WIDTH'(1);
        end
      end

      always_comb begin
        int nxt;
        nxt            = (int'(cand) == NUM_CLIENTS - 1) ? 0 : int'(cand) + 1;
        locked_d       = locked_q;
        lock_idx_d     = lock_idx_q;
        base_d         = base_q;
        credit_d       = credit_q;
        credit_owner_d = credit_owner_q;
        if (xfer) begin
          if (!eop[cand]) begin
            locked_d   = 1'b1;
            lock_idx_d = cand;
          end else begin
            locked_d       = 1'b0;
            credit_owner_d = cand;
            if (cnt >= w_eff) begin
              base_d   = NUM_CLIENTS'(1) << nxt;
              credit_d = '0;
            end else begin
              base_d   = NUM_CLIENTS'(1) << cand;
              credit_d = cnt;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          base_q         <= NUM_CLIENTS'(1);
          credit_q       <= '0;
          credit_owner_q <= '0;
        end else begin
          base_q         <= base_d;
          credit_q       <= credit_d;
          credit_owner_q <= credit_owner_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ofs_plat_prim_arb_wrr_pkt.sv
// Scoreboard bench for the packet-locking WRR arbiter: expected winners are
// queued as stimulus is driven and retired on each observed transfer.
module tb_ofs_plat_prim_arb_wrr_pkt;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ena;
  logic [N-1:0]  request;
  logic [N-1:0]  eop;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  grant;
  logic [1:0]    grantIdx;
  logic          valid;
  logic          locked;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  int seq1[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
  int seq6[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  ofs_plat_prim_arb_wrr_pkt #(.NUM_CLIENTS(N), .WEIGHT_WIDTH(WW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ena      (ena),
    .request  (request),
    .eop      (eop),
    .weight   (weight),
    .grant    (grant),
    .grantIdx (grantIdx),
    .valid    (valid),
    .locked   (locked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observe outputs mid-cycle; any transfer retires one scoreboard entry.
  task automatic sample();
    int e;
    @(negedge clk);
    if (reset_n && (|grant)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("xfer idx=%0d grant=%b locked=%0d", grantIdx, grant, locked);
        chk("sb_idx", 32'(grantIdx), 32'(e));
        chk("sb_grant", 32'(grant), 32'(1) << e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ena     = 1'b0;
    request = '0;
    eop     = '0;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    adv();
    adv();
    sample();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_idx", 32'(grantIdx), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_locked", 32'(locked), 0);
    adv();
    reset_n = 1'b1;

    // Plain round robin, all weights 1.
    request = 4'b1111;
    eop     = 4'b1111;
    ena     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(seq1[i]);
      sample();
      adv();
    end

    // Client 0 gets three packets per turn.
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(seq2[i]);
      sample();
      adv();
    end

    // Client 1 four-beat packet with a one-cycle request gap.
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    request = 4'b1111;
    eop     = 4'b1101;
    exp_q.push_back(1);
    sample();
    chk("pkt_beat1_locked", 32'(locked), 0);
    adv();
    exp_q.push_back(1);
    sample();
    chk("pkt_beat2_locked", 32'(locked), 1);
    adv();
    request = 4'b1101;
    sample();
    chk("gap_grant", 32'(grant), 0);
    chk("gap_valid", 32'(valid), 0);
    chk("gap_locked", 32'(locked), 1);
    adv();
    request = 4'b1111;
    exp_q.push_back(1);
    sample();
    chk("pkt_beat3_locked", 32'(locked), 1);
    adv();
    eop = 4'b1111;
    exp_q.push_back(1);
    sample();
    chk("pkt_beat4_locked", 32'(locked), 1);
    adv();
    exp_q.push_back(2);
    sample();
    chk("post_pkt_locked", 32'(locked), 0);
    adv();
    request = '0;

    // Back-pressure: candidate visible, nothing granted, base holds.
    ena     = 1'b0;
    request = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_grant", 32'(grant), 0);
      chk("stall_valid", 32'(valid), 1);
      chk("stall_idx", 32'(grantIdx), 1);
      adv();
    end
    ena = 1'b1;
    exp_q.push_back(1);
    sample();
    adv();

    // Reset while client 2 is mid-packet.
    request = 4'b0100;
    eop     = 4'b0000;
    exp_q.push_back(2);
    sample();
    adv();
    request = '0;
    sample();
    chk("prerst_locked", 32'(locked), 1);
    chk("prerst_valid", 32'(valid), 0);
    adv();
    reset_n = 1'b0;
    adv();
    reset_n = 1'b1;
    request = 4'b1111;
    eop     = 4'b1111;
    exp_q.push_back(0);
    sample();
    chk("postrst_locked", 32'(locked), 0);
    adv();

    // Weight 0 behaves as weight 1.
    weight = {4'd1, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(seq6[i]);
      sample();
      adv();
    end
    request = '0;
    sample();
    chk("idle_valid", 32'(valid), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ofs_plat_prim_arb_wrr_pkt.md
Name: ofs_plat_prim_arb_wrr_pkt

Overview:
- Weighted round-robin arbiter with packet locking, for multiplexing multi-beat request streams from NUM_CLIENTS sources onto one shared channel.
- Grant is combinational, in the same cycle as request.
- Once a client wins a multi-beat packet, it holds the channel until its end-of-packet beat transfers.
- Each client may win up to its programmed weight of whole packets in a row before priority rotates.

Parameters:
- NUM_CLIENTS, 4: number of requesters; must be at least 1.
- WEIGHT_WIDTH, 4: bit width of each per-client weight and of the internal credit counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- ena  in  1  downstream ready; a transfer occurs when ena=1 and grant is non-zero.
- request  in  NUM_CLIENTS  per-client beat valid.
- eop  in  NUM_CLIENTS  per-client end-of-packet flag for the current beat; single-beat packets drive eop=1.
- weight  in  NUM_CLIENTS*WEIGHT_WIDTH  per-client packet quantum; client i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- grant  out  NUM_CLIENTS  one-hot grant, qualified by ena.
- grantIdx  out  max(1,$clog2(NUM_CLIENTS))  index of the candidate winner; valid when valid=1, independent of ena.
- valid  out  1  a candidate winner exists this cycle.
- locked  out  1  arbiter is mid-packet.

Behaviour:
- State registers:
  - base: one-hot priority vector; reset value 1.
  - locked: reset value 0.
  - lock_idx: reset value 0.
  - credit: WEIGHT_WIDTH bits; reset value 0.
  - credit_owner: reset value 0.
- Reset is synchronous and may arrive mid-packet. It clears the lock and all state; in the first cycle after reset, arbitration is purely round-robin from client 0.
- Output reset values: all outputs are combinational. With request=0 they are grant=0, grantIdx=0, valid=0, locked=0.
- Unlocked (locked=0), candidate selection:
  - The candidate is the first requester at or after base, scanning upward and wrapping to 0.
  - valid = |request.
  - grant = onehot(candidate) & {NUM_CLIENTS{ena}}.
- Locked (locked=1), candidate selection:
  - The only possible candidate is lock_idx.
  - valid = request[lock_idx].
  - Other requesters are never granted, even if lock_idx is idle; idle cycles are bubbles.
- Effective weight: w_eff(i) = max(weight[i], 1); a weight of 0 is treated as 1.
- On a transfer by winner w with eop[w]=0 (mid-packet beat):
  - locked <= 1, lock_idx <= w.
  - base, credit and credit_owner are unchanged.
- On a transfer by winner w with eop[w]=1 (packet complete):
  - locked <= 0.
  - Compute cnt = (credit_owner==w) ? credit+1 : 1, using saturating arithmetic.
  - If cnt >= w_eff(w): base <= onehot((w+1) mod NUM_CLIENTS), credit <= 0, credit_owner <= w.
  - Otherwise: base <= onehot(w), credit <= cnt, credit_owner <= w.
  - weight is sampled only on this beat; changing weight mid-packet has no effect until eop.
- No transfer (ena=0 or valid=0): all state holds.
  - grantIdx and valid still reflect the candidate; grant is 0.
- If the base client stops requesting while it holds credit, round-robin selects the next requester, whose cnt restarts at 1.
- Wrap-around: after client NUM_CLIENTS-1 exhausts its weight, base returns to client 0.
- NUM_CLIENTS=1:
  - grant = ena & request, grantIdx = 0, valid = request.
  - locked tracks eop as above.
  - base and credit logic are omitted.
- Latency: grant is combinational (0 cycles); state updates on the next clk edge.

Test Plan:
- Reset, then request=4'b1111, eop=4'b1111, all weights 1, ena=1 for 8 cycles -> grantIdx sequence 0,1,2,3,0,1,2,3.
- weight[0]=3, other weights 1, all requesting single-beat packets -> grantIdx sequence 0,0,0,1,2,3,0,0,0.
- Client 1 sends a 4-beat packet (eop on beat 4) while clients 0, 2 and 3 request continuously; drop request[1] for 1 cycle mid-packet -> grant=4'b0010 on every client-1 beat, grant=0 in the gap cycle, locked=1 until the eop transfer, then grantIdx=2.
- ena=0 for 3 cycles with request=4'b0110 -> grant=0, valid=1, grantIdx=1 in all three cycles; base unchanged; first ena=1 cycle grants client 1.
- Assert reset_n=0 mid-packet with locked=1 and lock_idx=2 -> next cycle locked=0, and request=4'b1111 grants client 0.
- weight[2]=0 with all clients requesting -> client 2 wins exactly 1 packet per rotation, the same as weight 1.
